race_referee: RTL
=================

RACE_REFEREE -- requirements
Module: race_referee

Interface
REQ-001 Parameter FINISH_LINE_POS, default 2000, is the track position at which a player has finished.
REQ-002 Parameter GO_SECONDS, default 5, is the light-timer seconds value that starts the race.
REQ-003 Port clk, input, 1 bit: single clock, 65 MHz pixel-domain clock.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start_game, input, 1 bit: level signal from the menu; high while a game is selected.
REQ-006 Port back_to_menu, input, 1 bit: one-cycle pulse from the scoreboard that returns the game to the menu.
REQ-007 Port light_seconds, input, 12 bits: seconds count from the light-signals timer.
REQ-008 Ports p1_position and p2_position, input, 32 bits each: player track positions, unsigned.
REQ-009 Ports p1_time and p2_time, input, 22 bits each: running player time, seconds in [21:10] and milliseconds in [9:0].
REQ-010 Ports p1_key and p2_key, input, 1 bit each: accelerator key levels.
REQ-011 Ports lights_go, p1_enable and p2_enable, output, 1 bit each: race started; per-player controller and timer enable.
REQ-012 Ports p1_finished, p2_finished and end_game, output, 1 bit each: per-player finish flags; end_game when both players have finished.
REQ-013 Ports p1_final and p2_final, output, 22 bits each: latched finish times.
REQ-014 Port winner, output, 2 bits: 00 none, 01 P1, 10 P2, 11 draw.
REQ-015 Port false_start, output, 2 bits: bit0 is P1, bit1 is P2.

Function
REQ-016 The FSM SHALL have four states: IDLE, COUNTDOWN, RACING, FINISHED.
REQ-017 IDLE SHALL go to COUNTDOWN when start_game=1.
REQ-018 COUNTDOWN SHALL go to RACING when light_seconds==GO_SECONDS.
REQ-019 RACING SHALL go to FINISHED when both players have finished.
REQ-020 FINISHED SHALL hold until back_to_menu.
REQ-021 back_to_menu SHALL force IDLE from any state and clear every output to its reset value on the next edge, overriding all other events in the same cycle.
REQ-022 start_game falling in COUNTDOWN or RACING SHALL return the FSM to IDLE.
REQ-023 All outputs SHALL be registered, with exactly one clock of latency from the causing input.
REQ-024 lights_go SHALL be 1 in RACING and FINISHED.
REQ-025 pN_enable SHALL equal lights_go AND NOT pN_finished.
REQ-026 pN_finished SHALL set on the first cycle in RACING where pN_position >= FINISH_LINE_POS, using a 32-bit unsigned compare, and stay set.
REQ-027 pN_final SHALL capture pN_time in the same cycle pN_finished sets, and SHALL never update again until cleared.
REQ-028 winner SHALL be set once: to the first player to finish, by cycle.
REQ-029 If both players finish in the same cycle, the smaller captured time SHALL win; equal times SHALL give 11.
REQ-030 end_game SHALL equal p1_finished AND p2_finished.
REQ-031 Positions at or above FINISH_LINE_POS before RACING SHALL be ignored.

Reset
REQ-032 Reset asserted low SHALL immediately force IDLE and zero every output, including winner=00, false_start=00 and the final times.
REQ-033 Reset assertion mid-race SHALL discard all latched results.
REQ-034 Release of reset SHALL take effect on the next clk edge.

Configuration
REQ-035 With macro RACE_FALSE_START_EN defined, pN_key=1 in COUNTDOWN SHALL set false_start[N], sticky until back_to_menu or reset.
REQ-036 With RACE_FALSE_START_EN defined, a single false starter SHALL lose: winner is forced to the other player at race end, regardless of times.
REQ-037 With RACE_FALSE_START_EN defined, two false starters SHALL give winner 11.
REQ-038 Without RACE_FALSE_START_EN, keys SHALL be ignored and false_start SHALL be tied to 00.

Structure
REQ-039 Package race_pkg SHALL hold the state enum, the winner encoding constants, and the default FINISH_LINE_POS and GO_SECONDS.
REQ-040 A sub-module finish_latch SHALL be instantiated once per player; it holds the position compare, the finished flag and the time capture.

Verification
REQ-041 Directed scenario, normal race: start_game=1, light_seconds 0->5, P1 reaches 2000 while p1_time=0x00C05 (3 s 5 ms), P2 reaches 2000 later -> lights_go rises one cycle after light_seconds=5; p1_final=0x00C05; winner=01; end_game=1 after P2 finishes.
REQ-042 Directed scenario, same-cycle finish: both positions reach 2000 in the same cycle with p1_time=0x01000 and p2_time=0x00FFF -> winner=10.
REQ-043 Directed scenario, same-cycle finish with identical times -> winner=11.
REQ-044 Directed scenario, back_to_menu pulse in the same cycle as a P1 finish -> state returns to IDLE and all outputs read 0 next cycle; the finish is not latched.
REQ-045 Directed scenario, reset driven low mid-RACING -> all outputs 0 asynchronously; after release with start_game still 1, the FSM re-enters COUNTDOWN.
REQ-046 Directed scenario, false start (RACE_FALSE_START_EN defined): p1_key=1 at light_seconds=2, P1 finishes first -> false_start=01 and winner=10; with the macro undefined -> false_start=00 and winner=01.

Source files
------------

// File: rtl/race_pkg.sv
// Shared definitions for race_referee: FSM state encoding, winner codes,
// default track parameters and the winner decision helper.
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACING    = 2'd2,
    ST_FINISHED  = 2'd3
  } race_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [31:0] FINISH_LINE_POS_DEF = 32'd2000;
  localparam logic [11:0] GO_SECONDS_DEF      = 12'd5;

  // A recorded false start overrides the race result; otherwise earliest finisher, then smaller time.
  function automatic logic [1:0] decide_winner(
    input logic        hit1,
    input logic        hit2,
    input logic [21:0] t1,
    input logic [21:0] t2,
    input logic [1:0]  fs
  );
    logic [1:0] w;
    w = WIN_NONE;
    if (fs == 2'b01) w = WIN_P2;
    else if (fs == 2'b10) w = WIN_P1;
    else if (fs == 2'b11) w = WIN_DRAW;
    else if (hit1 && hit2) begin
      if (t1 < t2) w = WIN_P1;
      else if (t2 < t1) w = WIN_P2;
      else w = WIN_DRAW;
    end
    else if (hit1) w = WIN_P1;
    else if (hit2) w = WIN_P2;
    else w = WIN_NONE;
    return w;
  endfunction

endpackage

// File: rtl/finish_latch.sv
// Per-player finish detector: flags the first armed cycle at or past the
// finish line and captures the player's running time in that same cycle.
module finish_latch
  import race_pkg::*;
#(
  parameter logic [31:0] FINISH_LINE_POS = FINISH_LINE_POS_DEF
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_arm,
  input  logic        i_clear,
  input  logic [31:0] i_position,
  input  logic [21:0] i_time,
  output logic        o_hit,
  output logic        o_finished,
  output logic [21:0] o_final
);

  logic        r_finished;
  logic [21:0] r_final;
  logic        w_hit;

  assign w_hit      = i_arm & ~r_finished & (i_position >= FINISH_LINE_POS);
  assign o_hit      = w_hit;
  assign o_finished = r_finished;
  assign o_final    = r_final;

  // Clear wins over a same-cycle hit so an aborted race never latches a result.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_finished <= 1'b0;
      r_final    <= 22'd0;
    end else if (i_clear) begin
      r_finished <= 1'b0;
      r_final    <= 22'd0;
    end else if (w_hit) begin
      r_finished <= 1'b1;
      r_final    <= i_time;
    end else begin
      r_finished <= r_finished;
      r_final    <= r_final;
    end
  end

endmodule

// File: rtl/race_referee.sv
// Two-player race referee: countdown, finish detection, winner and end of game.
// Optional false-start penalty enabled by defining RACE_FALSE_START_EN.
module race_referee
  import race_pkg::*;
#(
  parameter logic [31:0] FINISH_LINE_POS = FINISH_LINE_POS_DEF,
  parameter logic [11:0] GO_SECONDS      = GO_SECONDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_game,
  input  logic        back_to_menu,
  input  logic [11:0] light_seconds,
  input  logic [31:0] p1_position,
  input  logic [31:0] p2_position,
  input  logic [21:0] p1_time,
  input  logic [21:0] p2_time,
  input  logic        p1_key,
  input  logic        p2_key,
  output logic        lights_go,
  output logic        p1_enable,
  output logic        p2_enable,
  output logic        p1_finished,
  output logic        p2_finished,
  output logic        end_game,
  output logic [21:0] p1_final,
  output logic [21:0] p2_final,
  output logic [1:0]  winner,
  output logic [1:0]  false_start
);

  race_state_t r_state, w_next_state;
  logic        r_lights_go, r_p1_enable, r_p2_enable, r_end_game;
  logic [1:0]  r_winner, w_winner_next;
  logic [1:0]  r_false_start, w_false_start_next;
  logic        w_clear, w_arm, w_in_race_next;
  logic        w_p1_hit, w_p2_hit, w_p1_fin, w_p2_fin;
  logic        w_p1_fin_next, w_p2_fin_next;

  finish_latch #(.FINISH_LINE_POS(FINISH_LINE_POS)) u_p1_latch (
    .clk(clk), .i_rst_n(reset), .i_arm(w_arm), .i_clear(w_clear),
    .i_position(p1_position), .i_time(p1_time),
    .o_hit(w_p1_hit), .o_finished(w_p1_fin), .o_final(p1_final)
  );

  finish_latch #(.FINISH_LINE_POS(FINISH_LINE_POS)) u_p2_latch (
    .clk(clk), .i_rst_n(reset), .i_arm(w_arm), .i_clear(w_clear),
    .i_position(p2_position), .i_time(p2_time),
    .o_hit(w_p2_hit), .o_finished(w_p2_fin), .o_final(p2_final)
  );

  // Next-state logic; back_to_menu overrides every other event.
  always_comb begin
    w_next_state = r_state;
    if (back_to_menu) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      w_next_state = start_game ? ST_COUNTDOWN : ST_IDLE;
        ST_COUNTDOWN: begin
          if (!start_game) w_next_state = ST_IDLE;
          else if (light_seconds == GO_SECONDS) w_next_state = ST_RACING;
          else w_next_state = ST_COUNTDOWN;
        end
        ST_RACING: begin
          if (!start_game) w_next_state = ST_IDLE;
          else if ((w_p1_fin | w_p1_hit) && (w_p2_fin | w_p2_hit)) w_next_state = ST_FINISHED;
          else w_next_state = ST_RACING;
        end
        ST_FINISHED:  w_next_state = ST_FINISHED;
        default:      w_next_state = ST_IDLE;
      endcase
    end
  end

  assign w_clear        = (w_next_state == ST_IDLE);
  assign w_arm          = (r_state == ST_RACING);
  assign w_in_race_next = (w_next_state == ST_RACING) || (w_next_state == ST_FINISHED);
  assign w_p1_fin_next  = ~w_clear & (w_p1_fin | w_p1_hit);
  assign w_p2_fin_next  = ~w_clear & (w_p2_fin | w_p2_hit);

`ifdef RACE_FALSE_START_EN
  // Keys pressed during the countdown are remembered until the menu is re-entered.
  always_comb begin
    w_false_start_next = r_false_start;
    if (back_to_menu) w_false_start_next = 2'b00;
    else if (r_state == ST_COUNTDOWN) w_false_start_next = r_false_start | {p2_key, p1_key};
    else w_false_start_next = r_false_start;
  end
`else
  logic w_unused_keys;
  assign w_unused_keys      = p1_key ^ p2_key;
  assign w_false_start_next = 2'b00;
`endif

  // Winner is decided once, on the first cycle any player crosses the line.
  always_comb begin
    w_winner_next = r_winner;
    if (w_clear) w_winner_next = WIN_NONE;
    else if ((r_winner == WIN_NONE) && (w_p1_hit || w_p2_hit))
      w_winner_next = decide_winner(w_p1_hit, w_p2_hit, p1_time, p2_time, r_false_start);
    else w_winner_next = r_winner;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_lights_go   <= 1'b0;
      r_p1_enable   <= 1'b0;
      r_p2_enable   <= 1'b0;
      r_end_game    <= 1'b0;
      r_winner      <= WIN_NONE;
      r_false_start <= 2'b00;
    end else begin
      r_state       <= w_next_state;
      r_lights_go   <= w_in_race_next;
      r_p1_enable   <= w_in_race_next & ~w_p1_fin_next;
      r_p2_enable   <= w_in_race_next & ~w_p2_fin_next;
      r_end_game    <= w_p1_fin_next & w_p2_fin_next;
      r_winner      <= w_winner_next;
      r_false_start <= w_false_start_next;
    end
  end

  assign lights_go   = r_lights_go;
  assign p1_enable   = r_p1_enable;
  assign p2_enable   = r_p2_enable;
  assign p1_finished = w_p1_fin;
  assign p2_finished = w_p2_fin;
  assign end_game    = r_end_game;
  assign winner      = r_winner;
  assign false_start = r_false_start;

endmodule
